counter_seq_ctrl: RTL and testbench
===================================

// Module: counter_seq_ctrl
// PURPOSE
//   Sequencer for the 8-bit incrementing counter datapath: owns the count register,
//   gates increments through a programmable prescaler, and stops at or wraps at a
//   programmed limit. Sits between a config/start master and the counter consumers.
//   Supports one-shot and periodic modes.
// PARAMETERS
//   WIDTH       8   count/limit width; the increment wraps modulo 2**WIDTH
//   PRESCALE_W  4   prescale field width; tick every (cfg_prescale+1) clk cycles
// PORTS
//   clk           in   1           single clock, rising edge
//   reset         in   1           asynchronous, active-high; clears all state
//   cfg_valid     in   1           config offer; transfers when cfg_valid & cfg_ready
//   cfg_ready     out  1           high in IDLE, ARMED, DONE; low in RUN
//   cfg_limit     in   WIDTH       terminal count value
//   cfg_mode      in   1           0 = one-shot, 1 = periodic
//   cfg_prescale  in   PRESCALE_W  tick divider minus one
//   start         in   1           one-cycle request to run from 0
//   stop          in   1           one-cycle request to halt (RUN only)
//   count         out  WIDTH       current count (registered)
//   busy          out  1           high in RUN
//   tc_pulse      out  1           one-cycle pulse, registered, on each terminal count
//   done          out  1           high in DONE (one-shot completed)
// BEHAVIOUR
// - Reset (async): state=IDLE, count=0, prescale counter pre=0, tc_pulse=0, busy=0,
//   done=0, latched config=0. cfg_ready=1 (decoded from IDLE).
// - All outputs except cfg_ready are registered. cfg_ready is decoded from state.
// - IDLE: a config transfer latches limit/mode/prescale and moves to ARMED.
//   start is ignored.
// - ARMED: a config transfer re-latches and stays in ARMED. It takes priority over a
//   same-cycle start, which is dropped. start (no cfg) -> RUN, count=0, pre=0.
//   stop is ignored.
// - RUN: each cycle, if pre==prescale then tick and pre<=0, else pre<=pre+1.
//   On a tick:
//     * count!=limit: count<=count+1
//     * count==limit: tc_pulse=1 next cycle; periodic -> count<=0;
//       one-shot -> count holds limit, state<=DONE
// - RUN: stop -> ARMED, count and pre frozen. stop beats a same-cycle tick: no
//   increment, no tc. start and cfg_valid are ignored in RUN (cfg_ready=0).
// - DONE: done=1, count holds limit. start -> RUN from count=0. A config transfer
//   -> ARMED and beats a same-cycle start.
// - Timing: a start sampled at edge E0 gives count=0 after E0. First tc_pulse is high
//   in the cycle after edge E0 + (limit+1)*(prescale+1).
//   Periodic tc period = (limit+1)*(prescale+1) cycles.
// - limit=0: every tick is terminal; count stays 0.
//   limit=2**WIDTH-1: full wrap 0xFF->0x00 in periodic mode.
// - Reset asserted mid-RUN: immediate return to IDLE values; no tc_pulse is emitted.
// TESTING
// 1. Reset during RUN at count=0x05 -> count=0, busy=0, done=0 without a clk edge;
//    cfg_ready=1.
// 2. One-shot, limit=3, prescale=0, start at E0 -> count 1,2,3 after E1..E3;
//    tc_pulse and done after E4; count holds 3.
// 3. Periodic, limit=0xFF, prescale=0 -> count wraps 0xFF->0x00; tc_pulse every
//    256 cycles, exactly one cycle wide.
// 4. Periodic, limit=1, prescale=2 -> count changes every 3 cycles; tc_pulse every
//    6 cycles.
// 5. stop on the same cycle as a terminal tick (count=limit) -> ARMED, count holds
//    limit, no tc_pulse. A later start restarts from 0.
// 6. ARMED with cfg_valid=1 and start=1 together -> new config latched, state stays
//    ARMED, busy stays 0.

Source files
------------

// File: rtl/counter_seq_ctrl_if.sv
// Config/start handshake and counter status bundle shared by the sequencer and its master.
// The master drives configuration and run control; the sequencer drives count and status.
interface counter_seq_ctrl_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [WIDTH-1:0]      cfg_limit;
    logic                  cfg_mode;
    logic [PRESCALE_W-1:0] cfg_prescale;
    logic                  start;
    logic                  stop;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  tc_pulse;
    logic                  done;

    modport master (
        output cfg_valid, cfg_limit, cfg_mode, cfg_prescale, start, stop,
        input  cfg_ready, count, busy, tc_pulse, done
    );

    modport slave (
        input  cfg_valid, cfg_limit, cfg_mode, cfg_prescale, start, stop,
        output cfg_ready, count, busy, tc_pulse, done
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Counter sequencer: owns the count register, divides increments with a prescaler and
// stops (one-shot) or wraps (periodic) at a programmed terminal count.
module counter_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    counter_seq_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]      CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]      CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] PRE_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] PRE_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    state_t                state_q,  state_d;
    logic [WIDTH-1:0]      count_q,  count_d;
    logic [PRESCALE_W-1:0] pre_q,    pre_d;
    logic [WIDTH-1:0]      limit_q,  limit_d;
    logic                  mode_q,   mode_d;
    logic [PRESCALE_W-1:0] presc_q,  presc_d;
    logic                  tc_q,     tc_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;

    logic cfg_ready_s;
    logic cfg_fire_s;
    logic tick_s;

    assign cfg_ready_s = (state_q != ST_RUN);
    assign cfg_fire_s  = bus.cfg_valid & cfg_ready_s;
    assign tick_s      = (pre_q == presc_q);

    // Next-state and datapath decisions for the sequencer
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pre_d   = pre_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        tc_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_fire_s) begin
                    limit_d = bus.cfg_limit;
                    mode_d  = bus.cfg_mode;
                    presc_d = bus.cfg_prescale;
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // A config transfer always wins over a same-cycle start
            ST_ARMED, ST_DONE: begin
                if (cfg_fire_s) begin
                    limit_d = bus.cfg_limit;
                    mode_d  = bus.cfg_mode;
                    presc_d = bus.cfg_prescale;
                    state_d = ST_ARMED;
                end else if (bus.start) begin
                    count_d = CNT_ZERO;
                    pre_d   = PRE_ZERO;
                    state_d = ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_d = ST_ARMED;
                end else if (tick_s) begin
                    pre_d = PRE_ZERO;
                    if (count_q != limit_q) begin
                        count_d = count_q + CNT_ONE;
                    end else begin
                        tc_d = 1'b1;
                        if (mode_q) begin
                            count_d = CNT_ZERO;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end else begin
                    pre_d = pre_q + PRE_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= CNT_ZERO;
            pre_q   <= PRE_ZERO;
            limit_q <= CNT_ZERO;
            mode_q  <= 1'b0;
            presc_q <= PRE_ZERO;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pre_q   <= pre_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            presc_q <= presc_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.cfg_ready = cfg_ready_s;
    assign bus.count     = count_q;
    assign bus.busy      = busy_q;
    assign bus.tc_pulse  = tc_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl: stimulus queues expected output snapshots per
// cycle, a monitor pops and compares them on the falling edge (or on demand while in reset).
module tb_counter_seq_ctrl;

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
        logic       busy;
        logic       done;
        logic       tc;
        logic       rdy;
        string      nm;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    event async_ev;

    counter_seq_ctrl_if #(.WIDTH(8), .PRESCALE_W(4)) bus_if ();

    counter_seq_ctrl #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int at, input logic [7:0] c, input logic b, input logic d,
                        input logic t, input logic r, input string nm);
        exp_t e;
        e.cyc = at; e.cnt = c; e.busy = b; e.done = d; e.tc = t; e.rdy = r; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic cfg(input logic [7:0] lim, input logic md, input logic [3:0] ps);
        bus_if.cfg_valid    = 1'b1;
        bus_if.cfg_limit    = lim;
        bus_if.cfg_mode     = md;
        bus_if.cfg_prescale = ps;
    endtask

    // Monitor: compare every due snapshot against the DUT outputs
    initial begin
        exp_t e;
        logic [11:0] got;
        logic [11:0] want;
        forever begin
            @(negedge clk or async_ev);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                got  = {bus_if.count, bus_if.busy, bus_if.done, bus_if.tc_pulse, bus_if.cfg_ready};
                want = {e.cnt, e.busy, e.done, e.tc, e.rdy};
                n_checks++;
                if (got !== want) begin
                    n_errors++;
                    $display("FAIL %s @cyc %0d: got cnt=%02h busy=%b done=%b tc=%b rdy=%b, want cnt=%02h busy=%b done=%b tc=%b rdy=%b",
                             e.nm, cyc, got[11:4], got[3], got[2], got[1], got[0],
                             e.cnt, e.busy, e.done, e.tc, e.rdy);
                end
            end
        end
    end

    initial begin
        int e0;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus_if.cfg_valid = 1'b0; bus_if.cfg_limit = 8'h00; bus_if.cfg_mode = 1'b0;
        bus_if.cfg_prescale = 4'h0; bus_if.start = 1'b0; bus_if.stop = 1'b0;

        repeat (2) step();
        push(cyc, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "reset_state");
        #1 -> async_ev;
        #1 reset = 1'b0;

        // start is ignored in IDLE
        bus_if.start = 1'b1; step(); bus_if.start = 1'b0;
        push(cyc, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "idle_start_ignored");

        // One-shot, limit 3, prescale 0
        cfg(8'd3, 1'b0, 4'd0); step(); bus_if.cfg_valid = 1'b0;
        push(cyc, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "cfg_to_armed");
        bus_if.start = 1'b1; step(); bus_if.start = 1'b0;
        e0 = cyc;
        push(e0,     8'd0, 1'b1, 1'b0, 1'b0, 1'b0, "oneshot_n0");
        push(e0 + 1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, "oneshot_n1");
        push(e0 + 2, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, "oneshot_n2");
        push(e0 + 3, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, "oneshot_n3");
        push(e0 + 4, 8'd3, 1'b0, 1'b1, 1'b1, 1'b1, "oneshot_tc_done");
        push(e0 + 5, 8'd3, 1'b0, 1'b1, 1'b0, 1'b1, "oneshot_hold");
        repeat (5) step();

        // DONE: config beats same-cycle start
        cfg(8'd1, 1'b1, 4'd2); bus_if.start = 1'b1; step();
        bus_if.cfg_valid = 1'b0; bus_if.start = 1'b0;
        push(cyc, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, "done_cfg_beats_start");

        // Periodic, limit 1, prescale 2: count changes every 3, tc every 6
        bus_if.start = 1'b1; step(); bus_if.start = 1'b0;
        e0 = cyc;
        for (int n = 0; n <= 13; n++)
            push(e0 + n, 8'((n / 3) % 2), 1'b1, 1'b0, (n == 6 || n == 12), 1'b0, "periodic_l1_p2");
        push(e0 + 14, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, "stop_to_armed");
        repeat (13) step();
        bus_if.stop = 1'b1; step(); bus_if.stop = 1'b0;

        // stop coincident with terminal tick
        cfg(8'd2, 1'b0, 4'd0); step(); bus_if.cfg_valid = 1'b0;
        bus_if.start = 1'b1; step(); bus_if.start = 1'b0;
        e0 = cyc;
        push(e0,     8'd0, 1'b1, 1'b0, 1'b0, 1'b0, "stoptc_n0");
        push(e0 + 1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, "stoptc_n1");
        push(e0 + 2, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, "stoptc_n2");
        push(e0 + 3, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, "stop_beats_tc");
        push(e0 + 4, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, "stop_no_late_tc");
        repeat (2) step();
        bus_if.stop = 1'b1; step(); bus_if.stop = 1'b0;
        step();
        bus_if.start = 1'b1; step(); bus_if.start = 1'b0;
        push(cyc, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, "restart_from_zero");
        step();
        push(cyc, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, "restart_inc");
        bus_if.stop = 1'b1; step(); bus_if.stop = 1'b0;
        push(cyc, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, "stop_freezes");

        // ARMED: cfg and start together, then limit 0 periodic
        cfg(8'd0, 1'b1, 4'd0); bus_if.start = 1'b1; step();
        bus_if.cfg_valid = 1'b0; bus_if.start = 1'b0;
        push(cyc, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, "armed_cfg_beats_start");
        bus_if.start = 1'b1; step(); bus_if.start = 1'b0;
        e0 = cyc;
        push(e0,     8'd0, 1'b1, 1'b0, 1'b0, 1'b0, "lim0_n0");
        push(e0 + 1, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, "lim0_tc1");
        push(e0 + 2, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, "lim0_tc2");
        push(e0 + 3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, "lim0_stop");
        repeat (2) step();
        bus_if.stop = 1'b1; step(); bus_if.stop = 1'b0;

        // Periodic full range: wrap 0xFF->0x00, tc every 256 cycles
        cfg(8'hFF, 1'b1, 4'd0); step(); bus_if.cfg_valid = 1'b0;
        bus_if.start = 1'b1; step(); bus_if.start = 1'b0;
        e0 = cyc;
        for (int n = 0; n <= 520; n++)
            push(e0 + n, 8'(n % 256), 1'b1, 1'b0, (n == 256 || n == 512), 1'b0, "wrap_ff");
        push(e0 + 521, 8'd8, 1'b0, 1'b0, 1'b0, 1'b1, "wrap_stop");
        repeat (520) step();
        bus_if.stop = 1'b1; step(); bus_if.stop = 1'b0;

        // Async reset in the middle of RUN at count 5
        bus_if.start = 1'b1; step(); bus_if.start = 1'b0;
        e0 = cyc;
        for (int n = 0; n <= 5; n++)
            push(e0 + n, 8'(n), 1'b1, 1'b0, 1'b0, 1'b0, "pre_reset_run");
        repeat (5) step();
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        push(cyc, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, "async_reset_mid_run");
        -> async_ev;
        @(posedge clk); #1;
        reset = 1'b0;
        push(cyc, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, "post_reset_idle");

        repeat (2) step();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
